// File: rtl/system_partition_bank_pkg.sv
// Shared parameters and helpers for the double-buffered partition register bank.
`ifndef SINGLE
`define SINGLE 32
`endif

package system_partition_bank_pkg;

  localparam int DEFAULT_WIDTH = `SINGLE;
  localparam int STEP_CNT_W    = 16;

  // Address width for n channels; never less than 1 so a port always exists.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/system_partition_bank_partition_channel.sv
// One partition channel: shadow word, active/prev words and the written flag.
module partition_channel
  import system_partition_bank_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter bit CLEAR_ON_COMMIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  output logic [WIDTH-1:0] active,
  output logic [WIDTH-1:0] prev,
  output logic             missing
);

  logic [WIDTH-1:0] shadow;
  logic             written;

  // A write landing on the commit edge still counts for the step being closed.
  assign missing = ~(written | wr_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      prev    <= '0;
      written <= 1'b0;
    end else if (commit) begin
      prev    <= active;
      active  <= wr_hit ? wr_data : shadow;
      written <= 1'b0;
      if (CLEAR_ON_COMMIT) begin
        shadow <= '0;
      end else if (wr_hit) begin
        shadow <= wr_data;
      end
    end else if (wr_hit) begin
      shadow  <= wr_data;
      written <= 1'b1;
    end
  end

endmodule

// File: rtl/system_partition_bank.sv
// Partition register bank: per-channel shadow writes, atomic commit at the step boundary.
module system_partition_bank
  import system_partition_bank_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int CHANNELS        = 8,
  parameter bit CLEAR_ON_COMMIT = 1'b0,
  parameter int AW              = clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        control_valuation_sig,
  output logic [CHANNELS*WIDTH-1:0]   cout_flat,
  output logic [CHANNELS*WIDTH-1:0]   cout_prev_flat,
  output logic                        commit_done,
  output logic [CHANNELS-1:0]         miss_mask,
  output logic                        err_incomplete,
  output logic                        err_addr,
  output logic [STEP_CNT_W-1:0]       step_cnt
);

  localparam logic [AW:0] CH_LIMIT = (AW + 1)'(CHANNELS);

  // The strobe is a single-cycle pulse; there is no backpressure on writes or commits.
  logic                addr_oob;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] missing;

  assign addr_oob = ({1'b0, wr_addr} >= CH_LIMIT);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign wr_hit[k] = wr_en && !addr_oob && (wr_addr == AW'(k));

    partition_channel #(
      .WIDTH           (WIDTH),
      .CLEAR_ON_COMMIT (CLEAR_ON_COMMIT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_hit  (wr_hit[k]),
      .wr_data (wr_data),
      .commit  (control_valuation_sig),
      .active  (cout_flat[k*WIDTH +: WIDTH]),
      .prev    (cout_prev_flat[k*WIDTH +: WIDTH]),
      .missing (missing[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_mask      <= '0;
      step_cnt       <= '0;
      commit_done    <= 1'b0;
      err_incomplete <= 1'b0;
      err_addr       <= 1'b0;
    end else begin
      commit_done    <= control_valuation_sig;
      err_incomplete <= control_valuation_sig && (|missing);
      if (control_valuation_sig) begin
        miss_mask <= missing;
        step_cnt  <= step_cnt + 1'b1;
      end
      if (wr_en && addr_oob) begin
        err_addr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_system_partition_bank.sv
// Directed bench: a hold-mode bank and a clear-on-commit bank driven with identical stimulus.
module tb_system_partition_bank;

  localparam int W  = 32;
  localparam int CH = 8;
  localparam int AW = 4;
  localparam int FW = CH * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          cv = 1'b0;

  logic [FW-1:0] cout0, prev0, cout1, prev1;
  logic          done0, done1, inc0, inc1, eaddr0, eaddr1;
  logic [CH-1:0] miss0, miss1;
  logic [15:0]   step0, step1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FW-1:0] p1, p2, exp0, exp1;

  always #5 clk = ~clk;

  system_partition_bank #(.WIDTH(W), .CHANNELS(CH), .CLEAR_ON_COMMIT(1'b0), .AW(AW)) dut_hold (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .control_valuation_sig(cv), .cout_flat(cout0), .cout_prev_flat(prev0),
    .commit_done(done0), .miss_mask(miss0), .err_incomplete(inc0),
    .err_addr(eaddr0), .step_cnt(step0)
  );

  system_partition_bank #(.WIDTH(W), .CHANNELS(CH), .CLEAR_ON_COMMIT(1'b1), .AW(AW)) dut_clear (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .control_valuation_sig(cv), .cout_flat(cout1), .cout_prev_flat(prev1),
    .commit_done(done1), .miss_mask(miss1), .err_incomplete(inc1),
    .err_addr(eaddr1), .step_cnt(step1)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] set_ch(input logic [FW-1:0] f, input int k, input logic [W-1:0] v);
    logic [FW-1:0] r;
    r = f;
    r[k*W +: W] = v;
    return r;
  endfunction

  task automatic wr(input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic commit();
    cv = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cout", cout0, '0);
    chk("rst_prev", prev0, '0);
    chk("rst_miss", FW'(miss0), '0);
    chk("rst_step", FW'(step0), '0);
    chk("rst_flags", FW'({done0, inc0, eaddr0}), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // commit with nothing written
    commit();
    chk("empty_cout", cout0, '0);
    chk("empty_miss", FW'(miss0), FW'(8'hFF));
    chk("empty_done", FW'(done0), FW'(1));
    chk("empty_inc", FW'(inc0), FW'(1));
    chk("empty_step", FW'(step0), FW'(1));
    @(posedge clk); #1;
    chk("empty_pulse_end", FW'({done0, inc0}), '0);

    // full write pass, then commit
    p1 = '0;
    for (int k = 0; k < CH; k++) begin
      wr(k, 32'h3F800000 + W'(k));
      p1 = set_ch(p1, k, 32'h3F800000 + W'(k));
    end
    chk("pass1_not_yet_visible", cout0, '0);
    commit();
    chk("pass1_cout", cout0, p1);
    chk("pass1_cout_clear", cout1, p1);
    chk("pass1_miss", FW'(miss0), '0);
    chk("pass1_done_inc", FW'({done0, inc0}), FW'(2'b10));
    chk("pass1_step", FW'(step0), FW'(2));
    @(posedge clk); #1;
    chk("pass1_done_end", FW'(done0), '0);

    // second pass: previous values move to cout_prev_flat
    p2 = '0;
    for (int k = 0; k < CH; k++) begin
      wr(k, 32'h41000000 + W'(k));
      p2 = set_ch(p2, k, 32'h41000000 + W'(k));
    end
    commit();
    chk("pass2_cout", cout0, p2);
    chk("pass2_prev", prev0, p1);
    chk("pass2_step", FW'(step0), FW'(3));

    // last write wins; unwritten channels hold (or read zero with clear-on-commit)
    wr(3, 32'h40000000);
    wr(3, 32'h40400000);
    commit();
    exp0 = set_ch(p2, 3, 32'h40400000);
    exp1 = set_ch('0, 3, 32'h40400000);
    chk("lastwin_cout", cout0, exp0);
    chk("lastwin_cout_clear", cout1, exp1);
    chk("lastwin_prev", prev0, p2);
    chk("lastwin_miss", FW'(miss0), FW'(8'hF7));
    chk("lastwin_inc", FW'(inc0), FW'(1));

    // write coinciding with commit
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h40A00000; cv = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; cv = 1'b0;
    exp0 = set_ch(exp0, 5, 32'h40A00000);
    exp1 = set_ch('0, 5, 32'h40A00000);
    chk("samecyc_cout", cout0, exp0);
    chk("samecyc_cout_clear", cout1, exp1);
    chk("samecyc_miss", FW'(miss0), FW'(8'hDF));
    commit();
    chk("samecyc_next_hold", cout0, exp0);
    chk("samecyc_next_clear", cout1, '0);
    chk("samecyc_next_prev_clear", prev1, exp1);
    chk("samecyc_next_miss", FW'(miss0), FW'(8'hFF));
    chk("samecyc_step", FW'(step0), FW'(6));

    // out-of-range address
    wr(9, 32'hDEADBEEF);
    chk("oob_err", FW'(eaddr0), FW'(1));
    chk("oob_cout_unchanged", cout0, exp0);
    commit();
    chk("oob_shadow_unchanged", cout0, exp0);
    chk("oob_miss", FW'(miss0), FW'(8'hFF));
    repeat (3) @(posedge clk);
    #1;
    chk("oob_err_sticky", FW'(eaddr0), FW'(1));

    // asynchronous reset mid-step
    wr(0, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("midrst_cout", cout0, '0);
    chk("midrst_prev", prev0, '0);
    chk("midrst_regs", FW'({miss0, step0, eaddr0, done0, inc0}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    commit();
    chk("midrst_commit_cout", cout0, '0);
    chk("midrst_commit_miss", FW'(miss0), FW'(8'hFF));
    chk("midrst_commit_step", FW'(step0), FW'(1));

    // step counter wrap via back-to-back commits
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cv = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    cv = 1'b0;
    chk("wrap_ffff", FW'(step0), FW'(16'hFFFF));
    chk("b2b_miss", FW'(miss0), FW'(8'hFF));
    commit();
    chk("wrap_zero", FW'(step0), '0);
    chk("wrap_zero_clear", FW'(step1), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
